// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants, the Chien-search FSM encoding and the multiply-by-alpha helper.
package gf_pkg;

  localparam int unsigned m         = 255;
  localparam int unsigned SIZE      = 8;
  localparam logic [8:0]  PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } chien_state_e;

  // Multiply by alpha: shift left, reduce when the MSB falls out.
  function automatic logic [SIZE-1:0] gf_xtime(input logic [SIZE-1:0] a);
    logic [SIZE-1:0] red;
    red = a[SIZE-1] ? PRIM_POLY[SIZE-1:0] : '0;
    return {a[SIZE-2:0], 1'b0} ^ red;
  endfunction

endpackage

// File: rtl/gf_poly_eval.sv
// Combinational evaluation of a flat GF(2^8) polynomial at one point (Horner form).
module gf_poly_eval
  import gf_pkg::*;
#(
  parameter  int unsigned n         = 8,
  localparam int unsigned flat_size = (n + 1) * SIZE
) (
  input  logic [flat_size-1:0] poly,
  input  logic [SIZE-1:0]      x,
  output logic [SIZE-1:0]      y
);

  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < SIZE; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Highest coefficient first so each step is acc * x + coeff.
  always_comb begin
    y = '0;
    for (int k = n; k >= 0; k--) begin
      y = gf_mul(y, x) ^ poly[k*SIZE +: SIZE];
    end
  end

endmodule

// File: rtl/chien_search.sv
// Sequential Chien search: one locator evaluation per cycle over alpha^0..alpha^(m-1),
// streaming root positions and reporting root count and consistency at the end.
module chien_search
  import gf_pkg::*;
#(
  parameter  int unsigned n         = 8,
  localparam int unsigned flat_size = (n + 1) * SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [flat_size-1:0] flat_lambda,
  input  logic [SIZE-1:0]      deg_lambda,
  output logic                 busy,
  output logic                 err_valid,
  output logic [SIZE-1:0]      err_pos,
  output logic                 done,
  output logic [SIZE-1:0]      num_roots,
  output logic                 fail
);

  localparam logic [SIZE-1:0] MSym    = SIZE'(m);
  localparam logic [SIZE-1:0] LastIdx = SIZE'(m - 1);

  chien_state_e state_q, state_d;

  logic [flat_size-1:0] lambda_q, lambda_d;
  logic [SIZE-1:0]      deg_q, deg_d;
  logic [SIZE-1:0]      x_q, x_d;
  logic [SIZE-1:0]      i_q, i_d;
  logic [SIZE-1:0]      count_q, count_d;
  logic                 err_valid_q, err_valid_d;
  logic [SIZE-1:0]      err_pos_q, err_pos_d;
  logic                 done_q, done_d;
  logic [SIZE-1:0]      num_roots_q, num_roots_d;
  logic                 fail_q, fail_d;
  logic [SIZE-1:0]      y;
  logic                 lambda0_zero;

  gf_poly_eval #(
    .n(n)
  ) u_eval (
    .poly(lambda_q),
    .x   (x_q),
    .y   (y)
  );

  assign lambda0_zero = (lambda_q[SIZE-1:0] == '0);

  always_comb begin
    state_d     = state_q;
    lambda_d    = lambda_q;
    deg_d       = deg_q;
    x_d         = x_q;
    i_d         = i_q;
    count_d     = count_q;
    err_valid_d = 1'b0;
    err_pos_d   = '0;
    done_d      = 1'b0;
    num_roots_d = num_roots_q;
    fail_d      = fail_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StScan;
          lambda_d    = flat_lambda;
          deg_d       = deg_lambda;
          x_d         = SIZE'(1);
          i_d         = '0;
          count_d     = '0;
          num_roots_d = '0;
          fail_d      = 1'b0;
        end
      end
      StScan: begin
        x_d = gf_xtime(x_q);
        i_d = i_q + 1'b1;
        if (y == '0) begin
          if (count_q != MSym) count_d = count_q + 1'b1;
          // A zero constant term means x=0 is a root; positions would be meaningless.
          if (!lambda0_zero) begin
            err_valid_d = 1'b1;
            err_pos_d   = (i_q == '0) ? '0 : MSym - i_q;
          end
        end
        if (i_q == LastIdx) begin
          state_d     = StDone;
          done_d      = 1'b1;
          num_roots_d = count_d;
          fail_d      = (count_d != deg_q) | lambda0_zero;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lambda_q    <= '0;
      deg_q       <= '0;
      x_q         <= SIZE'(1);
      i_q         <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_pos_q   <= '0;
      done_q      <= 1'b0;
      num_roots_q <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lambda_q    <= lambda_d;
      deg_q       <= deg_d;
      x_q         <= x_d;
      i_q         <= i_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_pos_q   <= err_pos_d;
      done_q      <= done_d;
      num_roots_q <= num_roots_d;
      fail_q      <= fail_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign err_valid = err_valid_q;
  assign err_pos   = err_pos_q;
  assign done      = done_q;
  assign num_roots = num_roots_q;
  assign fail      = fail_q;

endmodule
